// File: rtl/alu_sweep_ctrl.sv
// ALU self-test initiator: sweeps an operand table over all 8 function codes and signs the results.
// Latency: 2+SETTLE cycles per result with res_ready high; 8*NUM_PAIRS results per sweep.
// Backpressure: res_valid/res_data and the ALU operands hold until res_ready; abort drops a pending result.
module alu_sweep_ctrl #(
  parameter int          NUM_PAIRS = 3,
  parameter int          SETTLE    = 1,
  parameter logic [15:0] EXP_SIG   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_f,
  input  logic [7:0]  alu_q,
  input  logic        alu_cout,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [13:0] res_data,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] sig
);

  localparam int CW = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    pair;
  logic [2:0]    fcode;
  logic [CW-1:0] cnt;
  logic          hs;
  logic          last;
  logic          settled;

  // Operand table: {a, b}; entries beyond NUM_PAIRS-1 are never selected.
  function automatic logic [15:0] pair_ops(input logic [1:0] idx);
    case (idx)
      2'd0:    pair_ops = {8'd3,   8'd4};
      2'd1:    pair_ops = {8'd250, 8'd12};
      2'd2:    pair_ops = {8'd30,  8'd176};
      default: pair_ops = {8'd255, 8'd255};
    endcase
  endfunction

  assign hs      = (state == S_EMIT) && res_valid && res_ready;
  assign last    = (pair == 2'(NUM_PAIRS - 1)) && (fcode == 3'd7);
  assign settled = (cnt == CW'(1));
  assign busy    = (state == S_DRIVE) || (state == S_WAIT) || (state == S_EMIT);
  assign done    = (state == S_DONE);
  assign pass    = done && (sig == EXP_SIG);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; abort overrides everything, including a simultaneous start.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state_nxt = S_DRIVE;
        S_DRIVE: state_nxt = S_WAIT;
        S_WAIT:  if (settled) state_nxt = S_EMIT;
        S_EMIT:  if (hs) state_nxt = last ? S_DONE : S_DRIVE;
        S_DONE:  if (start) state_nxt = S_DRIVE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath: ALU operand registers, settle counter, result capture and signature fold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair      <= 2'd0;
      fcode     <= 3'd0;
      cnt       <= '0;
      alu_a     <= 8'd0;
      alu_b     <= 8'd0;
      alu_f     <= 3'd0;
      res_valid <= 1'b0;
      res_data  <= 14'd0;
      sig       <= 16'd0;
    end else if (abort) begin
      res_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            pair  <= 2'd0;
            fcode <= 3'd0;
            sig   <= 16'd0;
          end
        end
        S_DRIVE: begin
          {alu_a, alu_b} <= pair_ops(pair);
          alu_f          <= fcode;
          cnt            <= CW'(SETTLE);
        end
        S_WAIT: begin
          cnt <= cnt - CW'(1);
          if (settled) begin
            res_data  <= {pair, fcode, alu_cout, alu_q};
            res_valid <= 1'b1;
          end
        end
        S_EMIT: begin
          if (hs) begin
            res_valid <= 1'b0;
            sig       <= {sig[14:0], sig[15]} ^ {7'b0, alu_cout, alu_q};
            if (fcode == 3'd7) begin
              fcode <= 3'd0;
              pair  <= pair + 2'd1;
            end else begin
              fcode <= fcode + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sweep_ctrl.sv
// Bench for alu_sweep_ctrl: adder stub on the ALU side, transaction-level model of the sweep.
// Three instances share stimulus; two differ only in EXP_SIG to exercise pass/fail.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_alu_sweep_ctrl;

  localparam int NP = 3;

  // ---------------- behavioural model helpers ----------------
  function automatic logic [7:0] tab_a(input int p);
    case (p)
      0:       tab_a = 8'd3;
      1:       tab_a = 8'd250;
      2:       tab_a = 8'd30;
      default: tab_a = 8'd255;
    endcase
  endfunction

  function automatic logic [7:0] tab_b(input int p);
    case (p)
      0:       tab_b = 8'd4;
      1:       tab_b = 8'd12;
      2:       tab_b = 8'd176;
      default: tab_b = 8'd255;
    endcase
  endfunction

  // {cout, q} the adder stub produces for a table pair
  function automatic logic [8:0] alu_sum(input int p);
    alu_sum = 9'(tab_a(p)) + 9'(tab_b(p));
  endfunction

  // Result number idx of a sweep: pair idx/8, function idx%8
  function automatic logic [13:0] exp_data(input int idx);
    exp_data = {2'(idx / 8), 3'(idx % 8), alu_sum(idx / 8)};
  endfunction

  function automatic logic [15:0] sig_step(input logic [15:0] s, input logic [8:0] v);
    sig_step = ((s << 1) | (s >> 15)) ^ 16'(v);
  endfunction

  function automatic logic [15:0] model_sig(input int np);
    logic [15:0] s;
    s = 16'd0;
    for (int i = 0; i < 8 * np; i++) s = sig_step(s, alu_sum(i / 8));
    model_sig = s;
  endfunction

  localparam logic [15:0] GOLD_SIG = model_sig(NP);

  // ---------------- DUT wiring ----------------
  logic clk = 1'b0;
  logic rst_n, start, abort, res_ready;

  logic [7:0]  alu_a, alu_b, alu_q;
  logic [2:0]  alu_f;
  logic        alu_cout, res_valid, busy, done, pass;
  logic [13:0] res_data;
  logic [15:0] sig;

  logic [7:0]  alu_a_p, alu_b_p, alu_q_p;
  logic [2:0]  alu_f_p;
  logic        alu_cout_p, res_valid_p, busy_p, done_p, pass_p;
  logic [13:0] res_data_p;
  logic [15:0] sig_p;

  logic [7:0]  alu_a_f, alu_b_f, alu_q_f;
  logic [2:0]  alu_f_f;
  logic        alu_cout_f, res_valid_f, busy_f, done_f, pass_f;
  logic [13:0] res_data_f;
  logic [15:0] sig_f;

  assign {alu_cout,   alu_q}   = {1'b0, alu_a}   + {1'b0, alu_b};
  assign {alu_cout_p, alu_q_p} = {1'b0, alu_a_p} + {1'b0, alu_b_p};
  assign {alu_cout_f, alu_q_f} = {1'b0, alu_a_f} + {1'b0, alu_b_f};

  always #5 clk = ~clk;

  alu_sweep_ctrl #(.NUM_PAIRS(NP), .SETTLE(1), .EXP_SIG(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_q(alu_q), .alu_cout(alu_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .done(done), .pass(pass), .sig(sig));

  alu_sweep_ctrl #(.NUM_PAIRS(NP), .SETTLE(1), .EXP_SIG(GOLD_SIG)) dut_p (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .alu_a(alu_a_p), .alu_b(alu_b_p), .alu_f(alu_f_p), .alu_q(alu_q_p), .alu_cout(alu_cout_p),
    .res_valid(res_valid_p), .res_ready(res_ready), .res_data(res_data_p),
    .busy(busy_p), .done(done_p), .pass(pass_p), .sig(sig_p));

  alu_sweep_ctrl #(.NUM_PAIRS(NP), .SETTLE(1), .EXP_SIG(GOLD_SIG ^ 16'h0001)) dut_f (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .alu_a(alu_a_f), .alu_b(alu_b_f), .alu_f(alu_f_f), .alu_q(alu_q_f), .alu_cout(alu_cout_f),
    .res_valid(res_valid_f), .res_ready(res_ready), .res_data(res_data_f),
    .busy(busy_f), .done(done_f), .pass(pass_f), .sig(sig_f));

  // ---------------- checking state ----------------
  int n_chk = 0;
  int n_err = 0;
  int n_results = 0;

  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  int          m_idx = 0;
  logic [15:0] m_sig = 16'd0;
  logic        hold = 1'b0;
  logic [13:0] h_data;
  logic [18:0] h_alu;
  logic [15:0] h_sig;
  logic [13:0] got [0:23];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the transaction model, then advance the model by what this edge will do.
  task automatic monitor();
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_idx = 0; m_sig = 16'd0; hold = 1'b0;
      return;
    end
    if (hold) begin
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_data", 32'(res_data), 32'(h_data));
      chk("hold_alu", 32'({alu_a, alu_b, alu_f}), 32'(h_alu));
      chk("hold_sig", 32'(sig), 32'(h_sig));
    end
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("sig", 32'(sig), 32'(m_sig));
    chk("pass", 32'(pass), 32'(m_done && (m_sig == 16'h0000)));
    if (!m_busy) chk("valid_outside_sweep", 32'(res_valid), 32'd0);
    if (res_valid && m_busy)
      chk("alu_inputs", 32'({alu_a, alu_b, alu_f}),
          32'({tab_a(m_idx / 8), tab_b(m_idx / 8), 3'(m_idx % 8)}));
    hold = 1'b0;
    if (abort) begin
      m_busy = 1'b0; m_done = 1'b0;
    end else if (start && !m_busy) begin
      m_busy = 1'b1; m_done = 1'b0; m_sig = 16'd0; m_idx = 0;
    end else if (res_valid && res_ready) begin
      chk("res_data", 32'(res_data), 32'(exp_data(m_idx)));
      if (m_idx < 24) got[m_idx] = res_data;
      m_sig = sig_step(m_sig, alu_sum(m_idx / 8));
      m_idx++;
      n_results++;
      if (m_idx == 8 * NP) begin
        m_busy = 1'b0; m_done = 1'b1;
      end
    end else if (res_valid) begin
      hold = 1'b1; h_data = res_data; h_alu = {alu_a, alu_b, alu_f}; h_sig = sig;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_alu"}, 32'({alu_a, alu_b, alu_f}), 32'd0);
    chk({tag, "_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_data"}, 32'(res_data), 32'd0);
    chk({tag, "_flags"}, 32'({busy, done, pass}), 32'd0);
    chk({tag, "_sig"}, 32'(sig), 32'd0);
  endtask

  // mode 0: ready always high; 1: ready low 5 cycles on result 3; 2: random ready and start pulses
  task automatic run_sweep(input int mode, output int cyc);
    int bp;
    bp = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 2000) begin
      case (mode)
        0: res_ready = 1'b1;
        1: begin
          if (res_valid && m_idx == 3 && bp < 5) begin
            res_ready = 1'b0;
            bp++;
          end else begin
            res_ready = 1'b1;
          end
        end
        default: begin
          res_ready = ($urandom_range(0, 3) != 0);
          start     = ($urandom_range(0, 9) == 0);
        end
      endcase
      tick();
      cyc++;
    end
    start = 1'b0;
    res_ready = 1'b1;
    chk("sweep_completes", 32'(done), 32'd1);
  endtask

  initial begin
    int cyc;
    int base;
    int guard;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b1;
    #1;
    check_zero("reset0");
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_after_reset", 32'({busy, done, res_valid}), 32'd0);

    // Reset in the middle of a sweep
    start = 1'b1; tick(); start = 1'b0;
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid");
    tick(); tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("stay_idle", 32'({busy, res_valid}), 32'd0);

    // Full sweep, ready always high
    base = n_results;
    run_sweep(0, cyc);
    chk("sweep_cycles", 32'(cyc), 32'd72);
    chk("sweep_count", 32'(n_results - base), 32'd24);
    chk("result0", 32'(got[0]), 32'h0007);
    chk("result8", 32'(got[8]), 32'h1106);
    chk("result15", 32'(got[15]), 32'h1F06);
    chk("result23", 32'(got[23]), 32'h2ECE);
    chk("model_sig", 32'(m_sig), 32'h45BA);
    chk("final_sig", 32'(sig), 32'h45BA);
    chk("pass_main", 32'(pass), 32'd0);
    chk("pass_exact", 32'({pass_p, done_p}), 32'b11);
    chk("pass_off_by_one", 32'({pass_f, done_f}), 32'b01);
    tick();

    // Backpressure on result 3
    base = n_results;
    run_sweep(1, cyc);
    chk("bp_cycles", 32'(cyc), 32'd77);
    chk("bp_count", 32'(n_results - base), 32'd24);
    chk("bp_sig", 32'(sig), 32'h45BA);
    tick();

    // Abort after the handshake of result 10
    start = 1'b1; tick(); start = 1'b0;
    guard = 0;
    while (m_idx < 11 && guard < 200) begin
      tick();
      guard++;
    end
    chk("reach_result10", 32'(m_idx), 32'd11);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_idle", 32'({res_valid, busy, done, pass}), 32'd0);
    repeat (3) tick();
    // abort wins over a simultaneous start
    abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
    chk("abort_beats_start", 32'(busy), 32'd0);
    tick();
    base = n_results;
    run_sweep(0, cyc);
    chk("post_abort_first", 32'(got[0]), 32'h0007);
    chk("post_abort_count", 32'(n_results - base), 32'd24);

    // Random ready with start pulses during the sweep (must be ignored)
    for (int r = 0; r < 3; r++) begin
      base = n_results;
      run_sweep(2, cyc);
      chk("rand_count", 32'(n_results - base), 32'd24);
      chk("rand_sig", 32'(sig), 32'(GOLD_SIG));
      tick();
    end

    // Restart from DONE clears the signature
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_sig", 32'(sig), 32'd0);
    chk("restart_flags", 32'({busy, done}), 32'b10);
    guard = 0;
    while (!done && guard < 200) begin
      tick();
      guard++;
    end
    chk("restart_done", 32'(done), 32'd1);

    // Random aborts, some landing on a pending result
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(3, 60);
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < n; k++) begin
        res_ready = ($urandom_range(0, 2) != 0);
        tick();
      end
      abort = 1'b1; tick(); abort = 1'b0;
      res_ready = 1'b1;
      chk("rand_abort_idle", 32'({res_valid, busy, done}), 32'd0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
